// File: rtl/range_peak_pkg.sv
// Shared types, constants and the saturating magnitude helper for range_peak_finder.
// RANGE_PEAK_NEIGHBORS_EN widens the result packet with the peak's neighbour magnitudes.
package range_peak_pkg;

`ifdef RANGE_PEAK_NEIGHBORS_EN
    typedef enum logic [2:0] {
        SCAN,
        DRAIN,
        REPORT_IDX,
        REPORT_MAG,
        REPORT_LEFT,
        REPORT_RIGHT
    } state_t;

    localparam int RESULT_BEATS = 4;
`else
    typedef enum logic [2:0] {
        SCAN,
        DRAIN,
        REPORT_IDX,
        REPORT_MAG
    } state_t;

    localparam int RESULT_BEATS = 2;
`endif

    localparam logic [15:0] NO_PEAK_IDX = 16'hFFFF;

    // The most negative input has no positive twin, so it clamps to the largest magnitude.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x);
        logic [31:0] result;
        if (x == 32'sh8000_0000) begin
            result = 32'h7FFF_FFFF;
        end else if (x[31]) begin
            result = unsigned'(-x);
        end else begin
            result = unsigned'(x);
        end
        return result;
    endfunction

endpackage

// File: rtl/peak_tracker.sv
// Registered running-maximum tracker for one frame of magnitudes, with synchronous clear.
// RANGE_PEAK_NEIGHBORS_EN adds capture of the magnitudes either side of the current best bin.
module peak_tracker
    import range_peak_pkg::*;
#(
    parameter int SKIP_BINS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_beat,
    input  logic [15:0] i_bin,
    input  logic [31:0] i_mag,
    output logic [31:0] o_best_mag,
    output logic [31:0] o_next_mag,
    output logic [15:0] o_next_idx
`ifdef RANGE_PEAK_NEIGHBORS_EN
    ,
    output logic [31:0] o_left_mag,
    output logic [31:0] o_right_mag
`endif
);

    localparam logic [15:0] SKIP16 = 16'(SKIP_BINS);

    logic [31:0] r_best_mag;
    logic [15:0] r_best_idx;
    logic        w_update;

    // Strictly-greater compare keeps the earliest bin on ties.
    assign w_update   = i_beat && (i_bin >= SKIP16) && (i_mag > r_best_mag);
    assign o_next_mag = w_update ? i_mag : r_best_mag;
    assign o_next_idx = w_update ? i_bin : r_best_idx;
    assign o_best_mag = r_best_mag;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_best_mag <= '0;
            r_best_idx <= '0;
        end else if (i_clear) begin
            r_best_mag <= '0;
            r_best_idx <= '0;
        end else if (w_update) begin
            r_best_mag <= i_mag;
            r_best_idx <= i_bin;
        end
    end

`ifdef RANGE_PEAK_NEIGHBORS_EN
    logic [31:0] r_prev_mag;
    logic [31:0] r_left_mag;
    logic [31:0] r_right_mag;
    logic        r_wait_right;

    // The right neighbour arrives one beat after the peak; it stays 0 if no beat follows.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_mag   <= '0;
            r_left_mag   <= '0;
            r_right_mag  <= '0;
            r_wait_right <= 1'b0;
        end else if (i_clear) begin
            r_prev_mag   <= '0;
            r_left_mag   <= '0;
            r_right_mag  <= '0;
            r_wait_right <= 1'b0;
        end else if (i_beat) begin
            r_prev_mag <= i_mag;
            if (w_update) begin
                r_left_mag   <= r_prev_mag;
                r_right_mag  <= '0;
                r_wait_right <= 1'b1;
            end else if (r_wait_right) begin
                r_right_mag  <= i_mag;
                r_wait_right <= 1'b0;
            end
        end
    end

    assign o_left_mag  = r_left_mag;
    assign o_right_mag = r_right_mag;
`endif

endmodule

// File: rtl/range_peak_finder.sv
// Per-frame peak search over an averaged AXI-Stream frame, reported as an (index, magnitude) packet.
// RANGE_PEAK_NEIGHBORS_EN extends the packet with the left and right neighbour magnitudes.
module range_peak_finder
    import range_peak_pkg::*;
#(
    parameter int          C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int          C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int          SAMPLES_PER_FRAME      = 6144,
    parameter int          SKIP_BINS              = 16,
    parameter logic [31:0] THRESHOLD              = 32'd64
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_areset,
    input  logic                                s00_axis_tvalid,
    input  logic                                s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    output logic                                s00_axis_tready,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                frame_error
);

    localparam logic [15:0] LAST_BIN  = 16'(SAMPLES_PER_FRAME - 1);
    localparam logic [1:0]  LAST_BEAT = 2'(RESULT_BEATS - 1);

    state_t r_state;
    state_t w_next_state;

    logic [15:0] r_bin_cnt;
    logic [1:0]  r_out_beat;
    logic [1:0]  w_out_beat_next;
    logic        r_s_tready;
    logic        r_m_tvalid;
    logic        r_m_tlast;
    logic        r_frame_error;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_m_tdata;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] w_m_tdata;

    logic        w_s_beat;
    logic        w_scan_beat;
    logic        w_m_hs;
    logic        w_clear;
    logic        w_frame_err;
    logic        w_next_report;
    logic [31:0] w_mag;
    logic [31:0] w_best_mag;
    logic [31:0] w_next_mag;
    logic [15:0] w_next_idx;
    logic        w_unused;
`ifdef RANGE_PEAK_NEIGHBORS_EN
    logic [31:0] w_left_mag;
    logic [31:0] w_right_mag;
`endif

    assign w_unused    = ^s00_axis_tstrb;
    assign w_s_beat    = s00_axis_tvalid && r_s_tready;
    assign w_scan_beat = w_s_beat && (r_state == SCAN);
    assign w_m_hs      = r_m_tvalid && m00_axis_tready;
    assign w_clear     = w_m_hs && r_m_tlast;
    assign w_mag       = abs_sat(s00_axis_tdata);

    peak_tracker #(
        .SKIP_BINS (SKIP_BINS)
    ) u_tracker (
        .i_clk      (s00_axis_aclk),
        .i_rst      (s00_axis_areset),
        .i_clear    (w_clear),
        .i_beat     (w_scan_beat),
        .i_bin      (r_bin_cnt),
        .i_mag      (w_mag),
        .o_best_mag (w_best_mag),
        .o_next_mag (w_next_mag),
        .o_next_idx (w_next_idx)
`ifdef RANGE_PEAK_NEIGHBORS_EN
        ,
        .o_left_mag (w_left_mag),
        .o_right_mag(w_right_mag)
`endif
    );

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_frame_err  = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_s_beat) begin
                    if (s00_axis_tlast) begin
                        w_next_state = REPORT_IDX;
                        w_frame_err  = (r_bin_cnt != LAST_BIN);
                    end else if (r_bin_cnt == LAST_BIN) begin
                        w_next_state = DRAIN;
                        w_frame_err  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_s_beat && s00_axis_tlast) begin
                    w_next_state = REPORT_IDX;
                end
            end
            REPORT_IDX: begin
                if (w_m_hs) begin
                    w_next_state = REPORT_MAG;
                end
            end
`ifdef RANGE_PEAK_NEIGHBORS_EN
            REPORT_MAG: begin
                if (w_m_hs) begin
                    w_next_state = REPORT_LEFT;
                end
            end
            REPORT_LEFT: begin
                if (w_m_hs) begin
                    w_next_state = REPORT_RIGHT;
                end
            end
            REPORT_RIGHT: begin
                if (w_m_hs) begin
                    w_next_state = SCAN;
                end
            end
`else
            REPORT_MAG: begin
                if (w_m_hs) begin
                    w_next_state = SCAN;
                end
            end
`endif
            default: begin
                w_next_state = SCAN;
            end
        endcase
    end

    // Outputs are registered from the next state so tvalid rises right after the final beat.
    always_comb begin
        w_next_report   = (w_next_state != SCAN) && (w_next_state != DRAIN);
        w_out_beat_next = '0;
        if (w_next_report) begin
            w_out_beat_next = w_m_hs ? (r_out_beat + 2'd1) : r_out_beat;
        end
        w_m_tdata = '0;
        case (w_next_state)
            REPORT_IDX: begin
                if (w_next_mag < THRESHOLD) begin
                    w_m_tdata = {16'd0, NO_PEAK_IDX};
                end else begin
                    w_m_tdata = {16'd0, w_next_idx};
                end
            end
            REPORT_MAG:   w_m_tdata = w_best_mag;
`ifdef RANGE_PEAK_NEIGHBORS_EN
            REPORT_LEFT:  w_m_tdata = w_left_mag;
            REPORT_RIGHT: w_m_tdata = w_right_mag;
`endif
            default:      w_m_tdata = '0;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_s_tready    <= 1'b1;
            r_m_tvalid    <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_m_tdata     <= '0;
            r_frame_error <= 1'b0;
            r_out_beat    <= '0;
        end else begin
            r_s_tready    <= !w_next_report;
            r_m_tvalid    <= w_next_report;
            r_m_tlast     <= w_next_report && (w_out_beat_next == LAST_BEAT);
            r_m_tdata     <= w_m_tdata;
            r_frame_error <= w_frame_err;
            r_out_beat    <= w_out_beat_next;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_bin_cnt <= '0;
        end else if (w_clear) begin
            r_bin_cnt <= '0;
        end else if (w_scan_beat) begin
            r_bin_cnt <= r_bin_cnt + 16'd1;
        end
    end

    assign s00_axis_tready = r_s_tready;
    assign m00_axis_tvalid = r_m_tvalid;
    assign m00_axis_tlast  = r_m_tlast;
    assign m00_axis_tdata  = r_m_tdata;
    assign m00_axis_tstrb  = '1;
    assign frame_error     = r_frame_error;

endmodule
